// File: rtl/vscale_hpm_csr_bank.sv
// Machine-mode counter CSR bank: mcycle, minstret and N_HPM event counters
// with inhibit, user-access enable, sticky overflow status and interrupt.

// One 2*W-bit counter slot. A CSR write to either half replaces that half
// and suppresses the increment for the cycle; wrap flags an all-ones rollover.
module vscale_hpm_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         wr_lo,
  input  logic         wr_hi,
  input  logic [W-1:0] wv,
  output logic [2*W-1:0] cnt,
  output logic         wrap
);
  assign wrap = inc & ~wr_lo & ~wr_hi & (&cnt);

  // Counter state: write beats increment, reset beats both.
  always_ff @(posedge clk) begin
    if (reset)      cnt <= '0;
    else if (wr_lo) cnt[W-1:0] <= wv;
    else if (wr_hi) cnt[2*W-1:W] <= wv;
    else if (inc)   cnt <= cnt + 1'b1;
  end
endmodule

module vscale_hpm_csr_bank #(
  parameter int XPR_LEN  = 32,
  parameter int N_HPM    = 4,
  parameter int N_EVENTS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic [11:0]         addr,
  input  logic [2:0]          cmd,
  input  logic [XPR_LEN-1:0]  wdata,
  input  logic [1:0]          prv,
  input  logic                retire,
  input  logic [N_EVENTS-1:0] events,
  output logic [XPR_LEN-1:0]  rdata,
  output logic                illegal_access,
  output logic                ovf_irq
);
  localparam int CW = 2 * XPR_LEN;
  // Slot map shared by all per-counter registers: 0 mcycle, 2 minstret, 3+i hpm i.
  localparam logic [31:0] IMPL32 = 32'h5 | (((32'd1 << N_HPM) - 32'd1) << 3);
  localparam logic [XPR_LEN-1:0] IMPL     = XPR_LEN'(IMPL32);
  localparam logic [XPR_LEN-1:0] OVF_MASK = IMPL & ~XPR_LEN'(5);

  logic [XPR_LEN-1:0] mcounteren, mcountinhibit, mhpmovf, mhpmovfen;
  logic [XPR_LEN-1:0] mhpmevent [N_HPM];
  logic [CW-1:0]      cnt [32];
  logic [31:0]        wrap;
  logic [N_HPM-1:0]   ev_hit;

  logic [4:0] off;
  logic       in_b, in_c, cnt_hit, sel_en, sel_inh, sel_evt, sel_ovf, sel_ovfen;
  logic       defined, is_wr, fault, wen, wr_cnt;
  logic [XPR_LEN-1:0] rd_val, wv, clr, ovf_next, ovfen_next;

  assign off       = addr[4:0];
  assign in_b      = (addr[11:8] == 4'hB) && (addr[6:5] == 2'b00);
  assign in_c      = (addr[11:8] == 4'hC) && (addr[6:5] == 2'b00);
  assign cnt_hit   = (in_b | in_c) && IMPL32[off];
  assign sel_en    = addr == 12'h306;
  assign sel_inh   = addr == 12'h320;
  assign sel_evt   = (addr[11:5] == 7'h19) && (off >= 5'd3) && IMPL32[off];
  assign sel_ovf   = addr == 12'h7C0;
  assign sel_ovfen = addr == 12'h7C1;

  // Read mux; undefined addresses read 0 and mark the access as undefined.
  always_comb begin
    defined = 1'b0;
    rd_val  = '0;
    if (cnt_hit) begin
      defined = 1'b1;
      rd_val  = addr[7] ? cnt[off][CW-1:XPR_LEN] : cnt[off][XPR_LEN-1:0];
    end else if (sel_en) begin
      defined = 1'b1;
      rd_val  = mcounteren;
    end else if (sel_inh) begin
      defined = 1'b1;
      rd_val  = mcountinhibit;
    end else if (sel_evt) begin
      defined = 1'b1;
      for (int i = 0; i < N_HPM; i++)
        if (off == 5'(3 + i)) rd_val = mhpmevent[i];
    end else if (sel_ovf) begin
      defined = 1'b1;
      rd_val  = mhpmovf;
    end else if (sel_ovfen) begin
      defined = 1'b1;
      rd_val  = mhpmovfen;
    end
  end

  assign rdata = rd_val;

  // Access checks: undefined, write to read-only space, privilege, user enable.
  assign is_wr = |cmd[1:0];
  assign fault = !defined
              || (is_wr && addr[11:10] == 2'b11)
              || (addr[9:8] > prv)
              || (prv == 2'b00 && in_c && !mcounteren[off]);
  assign illegal_access = req & cmd[2] & fault;
  assign wen    = req & is_wr & ~fault;
  assign wr_cnt = wen & in_b & IMPL32[off];

  // Write operand for write/set/clear.
  always_comb begin
    case (cmd[1:0])
      2'd1:    wv = wdata;
      2'd2:    wv = rd_val | wdata;
      2'd3:    wv = rd_val & ~wdata;
      default: wv = '0;
    endcase
  end

  // Event selector decode: values outside 1..N_EVENTS never count.
  always_comb begin
    for (int i = 0; i < N_HPM; i++) begin
      ev_hit[i] = 1'b0;
      for (int k = 1; k <= N_EVENTS; k++)
        if (mhpmevent[i] == XPR_LEN'(k)) ev_hit[i] = events[k-1];
    end
  end

  for (genvar c = 0; c < 32; c++) begin : g_cnt
    if (IMPL32[c]) begin : g_on
      logic inc_c;
      if (c == 0) begin : g_cyc
        assign inc_c = ~mcountinhibit[0];
      end else if (c == 2) begin : g_ret
        assign inc_c = ~mcountinhibit[2] & retire;
      end else begin : g_hpm
        assign inc_c = ~mcountinhibit[c] & ev_hit[c-3];
      end
      vscale_hpm_counter #(.W(XPR_LEN)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_c),
        .wr_lo (wr_cnt & ~addr[7] & (off == 5'(c))),
        .wr_hi (wr_cnt &  addr[7] & (off == 5'(c))),
        .wv    (wv),
        .cnt   (cnt[c]),
        .wrap  (wrap[c])
      );
    end else begin : g_off
      assign cnt[c]  = '0;
      assign wrap[c] = 1'b0;
    end
  end

  // Overflow status: CSR update, then clear of a written counter's bit, then
  // hardware sets (a written counter never wraps, so its set cannot occur).
  always_comb begin
    clr        = wr_cnt ? (XPR_LEN'(1) << off) : '0;
    ovf_next   = (wen && sel_ovf) ? (wv & OVF_MASK) : mhpmovf;
    ovf_next   = (ovf_next & ~clr) | (XPR_LEN'(wrap) & OVF_MASK);
    ovfen_next = (wen && sel_ovfen) ? (wv & IMPL) : mhpmovfen;
  end

  // Control/status registers and the registered overflow interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcounteren    <= '0;
      mcountinhibit <= '0;
      mhpmovf       <= '0;
      mhpmovfen     <= '0;
      ovf_irq       <= 1'b0;
      for (int i = 0; i < N_HPM; i++) mhpmevent[i] <= '0;
    end else begin
      if (wen && sel_en)  mcounteren    <= wv & IMPL;
      if (wen && sel_inh) mcountinhibit <= wv & IMPL;
      for (int i = 0; i < N_HPM; i++)
        if (wen && sel_evt && off == 5'(3 + i)) mhpmevent[i] <= wv;
      mhpmovf   <= ovf_next;
      mhpmovfen <= ovfen_next;
      ovf_irq   <= |(ovf_next & ovfen_next);
    end
  end
endmodule

// File: tb/tb_vscale_hpm_csr_bank.sv
// Self-checking bench: directed sequences, a constant-expectation read table,
// and randomized traffic checked against a behavioural model.
module tb_vscale_hpm_csr_bank;
  localparam int NH = 4, NE = 8;
  localparam logic [31:0] T_IMPL = 32'h7D, T_OVF = 32'h78;
  localparam logic [2:0] NOP = 3'd0, RD = 3'd4, WR = 3'd5, ST = 3'd6, CL = 3'd7;

  logic clk = 1'b0, reset = 1'b1, req = 1'b0, retire = 1'b0;
  logic [11:0] addr = 12'h0;
  logic [2:0]  cmd = 3'd0;
  logic [31:0] wdata = 32'h0;
  logic [1:0]  prv = 2'd3;
  logic [7:0]  events = 8'h0;
  logic [31:0] rdata;
  logic illegal_access, ovf_irq;

  vscale_hpm_csr_bank #(.XPR_LEN(32), .N_HPM(NH), .N_EVENTS(NE)) dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .cmd(cmd), .wdata(wdata),
    .prv(prv), .retire(retire), .events(events), .rdata(rdata),
    .illegal_access(illegal_access), .ovf_irq(ovf_irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // Reference state
  bit          m_valid = 0;
  logic [63:0] m_mc, m_mi;
  logic [63:0] m_hpm [NH];
  logic [31:0] m_ev [NH];
  logic [31:0] m_en, m_inh, m_ovf, m_ovfen;
  logic        m_irq;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] put(input logic [63:0] v, input bit hi, input logic [31:0] w);
    return hi ? {w, v[31:0]} : {v[63:32], w};
  endfunction

  function automatic void m_lookup(input logic [11:0] a, output bit def, output logic [31:0] val);
    int rel, idx;
    logic [63:0] v;
    def = 0; val = 32'h0; v = 64'h0;
    if ((a >= 12'hB00 && a <= 12'hB9F) || (a >= 12'hC00 && a <= 12'hC9F)) begin
      rel = int'(a) - ((a >= 12'hC00) ? 3072 : 2816);
      idx = rel % 128;
      if (idx == 0)                      begin def = 1; v = m_mc; end
      else if (idx == 2)                 begin def = 1; v = m_mi; end
      else if (idx >= 3 && idx < 3 + NH) begin def = 1; v = m_hpm[idx-3]; end
      if (def) val = (rel >= 128) ? v[63:32] : v[31:0];
    end else if (a == 12'h306) begin def = 1; val = m_en; end
    else if (a == 12'h320) begin def = 1; val = m_inh; end
    else if (a >= 12'h323 && int'(a) < 'h323 + NH) begin def = 1; val = m_ev[int'(a) - 'h323]; end
    else if (a == 12'h7C0) begin def = 1; val = m_ovf; end
    else if (a == 12'h7C1) begin def = 1; val = m_ovfen; end
  endfunction

  function automatic bit m_fault(input logic [11:0] a, input logic [2:0] c, input logic [1:0] p);
    bit def;
    logic [31:0] v;
    m_lookup(a, def, v);
    if (!def) return 1;
    if (c[1:0] != 2'b00 && a >= 12'hC00) return 1;
    if (a[9:8] > p) return 1;
    if (p == 2'd0 && a >= 12'hC00 && a <= 12'hC9F && !m_en[(int'(a) - 3072) % 128]) return 1;
    return 0;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic m_step();
    bit def, f, we, hit;
    int rel, idx;
    logic [31:0] rv, wv, clr, hw, n_en, n_inh, n_ovf, n_ovfen;
    logic [63:0] n_mc, n_mi;
    logic [63:0] n_hpm [NH];
    logic [31:0] n_ev [NH];
    if (reset) begin
      m_mc = 0; m_mi = 0; m_en = 0; m_inh = 0; m_ovf = 0; m_ovfen = 0; m_irq = 0;
      for (int i = 0; i < NH; i++) begin m_hpm[i] = 0; m_ev[i] = 0; end
      m_valid = 1;
      return;
    end
    m_lookup(addr, def, rv);
    f  = m_fault(addr, cmd, prv);
    we = req && (cmd[1:0] != 2'b00) && !f;
    case (cmd[1:0])
      2'd1:    wv = wdata;
      2'd2:    wv = rv | wdata;
      2'd3:    wv = rv & ~wdata;
      default: wv = 32'h0;
    endcase
    n_mc = m_inh[0] ? m_mc : m_mc + 64'd1;
    n_mi = (!m_inh[2] && retire) ? m_mi + 64'd1 : m_mi;
    hw = 0; clr = 0;
    for (int i = 0; i < NH; i++) begin
      hit = (m_ev[i] >= 1) && (m_ev[i] <= NE) && events[m_ev[i] - 1] && !m_inh[3+i];
      n_hpm[i] = m_hpm[i];
      n_ev[i]  = m_ev[i];
      if (hit) begin
        if (m_hpm[i] == 64'hFFFF_FFFF_FFFF_FFFF) hw[3+i] = 1'b1;
        n_hpm[i] = m_hpm[i] + 64'd1;
      end
    end
    n_en = m_en; n_inh = m_inh; n_ovf = m_ovf; n_ovfen = m_ovfen;
    if (we) begin
      if (addr >= 12'hB00 && addr <= 12'hB9F) begin
        rel = int'(addr) - 2816;
        idx = rel % 128;
        if (idx == 0)      n_mc = put(m_mc, rel >= 128, wv);
        else if (idx == 2) n_mi = put(m_mi, rel >= 128, wv);
        else begin
          n_hpm[idx-3] = put(m_hpm[idx-3], rel >= 128, wv);
          hw[idx] = 1'b0;
          clr[idx] = 1'b1;
        end
      end
      else if (addr == 12'h306) n_en = wv & T_IMPL;
      else if (addr == 12'h320) n_inh = wv & T_IMPL;
      else if (addr >= 12'h323 && int'(addr) < 'h323 + NH) n_ev[int'(addr) - 'h323] = wv;
      else if (addr == 12'h7C0) n_ovf = wv & T_OVF;
      else if (addr == 12'h7C1) n_ovfen = wv & T_IMPL;
    end
    n_ovf = (n_ovf & ~clr) | hw;
    m_mc = n_mc; m_mi = n_mi; m_en = n_en; m_inh = n_inh; m_ovf = n_ovf; m_ovfen = n_ovfen;
    for (int i = 0; i < NH; i++) begin m_hpm[i] = n_hpm[i]; m_ev[i] = n_ev[i]; end
    m_irq = |(n_ovf & n_ovfen);
  endtask

  task automatic drive(input logic r, input logic [11:0] a, input logic [2:0] c, input logic [31:0] w);
    bit def;
    logic [31:0] v;
    req = r; addr = a; cmd = c; wdata = w;
    #1;
    if (m_valid) begin
      m_lookup(a, def, v);
      chk32("model_rdata", rdata, v);
      chk1("model_illegal", illegal_access, r && c[2] && m_fault(a, c, prv));
    end
  endtask

  task automatic idle();
    drive(1'b0, 12'h0, NOP, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    m_step();
    #1;
    if (m_valid) chk1("model_ovf_irq", ovf_irq, m_irq);
  endtask

  typedef struct {
    logic r; logic [11:0] a; logic [2:0] c; logic [1:0] p;
    logic [31:0] exp_rd; logic exp_ill;
  } vec_t;
  vec_t tbl [22];

  logic [11:0] pool [16];
  logic [63:0] frozen;

  initial begin
    tbl[0]  = '{1'b1, 12'hB00, RD, 2'd3, 32'd1,  1'b0};
    tbl[1]  = '{1'b1, 12'hB80, RD, 2'd3, 32'd0,  1'b0};
    tbl[2]  = '{1'b1, 12'hB02, RD, 2'd3, 32'd0,  1'b0};
    tbl[3]  = '{1'b1, 12'hB01, RD, 2'd3, 32'd0,  1'b1};
    tbl[4]  = '{1'b1, 12'hB06, RD, 2'd3, 32'd0,  1'b0};
    tbl[5]  = '{1'b1, 12'hB07, RD, 2'd3, 32'd0,  1'b1};
    tbl[6]  = '{1'b1, 12'h320, RD, 2'd3, 32'h7D, 1'b0};
    tbl[7]  = '{1'b1, 12'h306, RD, 2'd3, 32'd0,  1'b0};
    tbl[8]  = '{1'b1, 12'h321, RD, 2'd3, 32'd0,  1'b1};
    tbl[9]  = '{1'b1, 12'h327, RD, 2'd3, 32'd0,  1'b1};
    tbl[10] = '{1'b1, 12'h7C0, RD, 2'd3, 32'd0,  1'b0};
    tbl[11] = '{1'b1, 12'h7C1, RD, 2'd3, 32'd0,  1'b0};
    tbl[12] = '{1'b1, 12'h7C2, RD, 2'd3, 32'd0,  1'b1};
    tbl[13] = '{1'b1, 12'hC00, RD, 2'd3, 32'd1,  1'b0};
    tbl[14] = '{1'b1, 12'hC00, RD, 2'd0, 32'd1,  1'b1};
    tbl[15] = '{1'b1, 12'h306, RD, 2'd0, 32'd0,  1'b1};
    tbl[16] = '{1'b0, 12'h123, RD, 2'd3, 32'd0,  1'b0};
    tbl[17] = '{1'b1, 12'h123, NOP, 2'd3, 32'd0, 1'b0};
    tbl[18] = '{1'b1, 12'hC00, WR, 2'd3, 32'd1,  1'b1};
    tbl[19] = '{1'b1, 12'hBA0, RD, 2'd3, 32'd0,  1'b1};
    tbl[20] = '{1'b1, 12'hB20, RD, 2'd3, 32'd0,  1'b1};
    tbl[21] = '{1'b1, 12'h323, RD, 2'd3, 32'd0,  1'b0};
    pool = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB83, 12'hB06, 12'hB86,
             12'hC00, 12'hC03, 12'h306, 12'h320, 12'h323, 12'h324, 12'h7C0, 12'h7C1};

    // Reset state
    reset = 1'b1; prv = 2'd3;
    idle(); step(); step();
    drive(1'b1, 12'hB00, RD, 32'h0); chk32("rst_mcycle", rdata, 32'd0);
    drive(1'b1, 12'h306, RD, 32'h0); chk32("rst_mcounteren", rdata, 32'd0);
    chk1("rst_irq", ovf_irq, 1'b0);
    idle();
    reset = 1'b0; retire = 1'b1;
    repeat (10) step();
    retire = 1'b0;
    drive(1'b1, 12'hB00, RD, 32'h0); chk32("mcycle_10", rdata, 32'd10);
    drive(1'b1, 12'hB02, RD, 32'h0); chk32("minstret_10", rdata, 32'd10);
    drive(1'b1, 12'hB80, RD, 32'h0); chk32("mcycleh_0", rdata, 32'd0);
    drive(1'b1, 12'h123, RD, 32'h0); chk32("undef_rdata", rdata, 32'd0);
    chk1("undef_illegal", illegal_access, 1'b1);
    idle(); step();

    // Event selection
    drive(1'b1, 12'h323, WR, 32'd2); step(); idle();
    events = 8'h02; repeat (5) step();
    events = 8'h01; repeat (3) step();
    events = 8'h00;
    drive(1'b1, 12'hB03, RD, 32'h0); chk32("hpm0_5", rdata, 32'd5);
    drive(1'b1, 12'h323, WR, 32'(NE + 1)); step(); idle();
    events = 8'hFF; repeat (4) step();
    events = 8'h00;
    drive(1'b1, 12'hB03, RD, 32'h0); chk32("hpm0_sel_oob", rdata, 32'd5);
    idle(); step();

    // Overflow and interrupt
    drive(1'b1, 12'hB83, WR, 32'hFFFF_FFFF); step();
    drive(1'b1, 12'hB03, WR, 32'hFFFF_FFFE); step();
    drive(1'b1, 12'h323, WR, 32'd3); step();
    drive(1'b1, 12'h7C1, WR, 32'h8); step();
    idle(); events = 8'h04; step();
    drive(1'b1, 12'hB03, RD, 32'h0); chk32("hpm0_lo_ones", rdata, 32'hFFFF_FFFF);
    drive(1'b1, 12'hB83, RD, 32'h0); chk32("hpm0_hi_ones", rdata, 32'hFFFF_FFFF);
    chk1("irq_before_wrap", ovf_irq, 1'b0);
    idle(); step(); events = 8'h00;
    drive(1'b1, 12'hB03, RD, 32'h0); chk32("hpm0_lo_wrap", rdata, 32'd0);
    drive(1'b1, 12'hB83, RD, 32'h0); chk32("hpm0_hi_wrap", rdata, 32'd0);
    drive(1'b1, 12'h7C0, RD, 32'h0); chk32("mhpmovf_set", rdata, 32'h8);
    chk1("irq_after_wrap", ovf_irq, 1'b1);
    drive(1'b1, 12'h7C0, CL, 32'h8); step(); idle();
    chk1("irq_cleared", ovf_irq, 1'b0);
    drive(1'b1, 12'h7C0, RD, 32'h0); chk32("mhpmovf_clr", rdata, 32'h0);
    idle(); step();

    // Inhibit
    drive(1'b1, 12'h320, ST, 32'h1); step(); idle();
    frozen = m_mc;
    repeat (20) step();
    drive(1'b1, 12'hB00, RD, 32'h0); chk32("mcycle_frozen", rdata, frozen[31:0]);
    drive(1'b1, 12'h320, CL, 32'h1); step(); idle();
    repeat (5) step();
    drive(1'b1, 12'hB00, RD, 32'h0); chk32("mcycle_resumed", rdata, frozen[31:0] + 32'd5);
    idle(); step();

    // Privilege and user enable
    prv = 2'd0;
    drive(1'b1, 12'hC00, RD, 32'h0); chk1("u_cycle_disabled", illegal_access, 1'b1);
    prv = 2'd3;
    drive(1'b1, 12'h306, WR, 32'h1); step();
    prv = 2'd0;
    drive(1'b1, 12'hC00, RD, 32'h0); chk1("u_cycle_enabled", illegal_access, 1'b0);
    drive(1'b1, 12'hC02, RD, 32'h0); chk1("u_instret_disabled", illegal_access, 1'b1);
    drive(1'b1, 12'hB00, RD, 32'h0); chk1("u_mcycle", illegal_access, 1'b1);
    prv = 2'd3;
    drive(1'b1, 12'hC00, WR, 32'h0); chk1("m_write_ro", illegal_access, 1'b1);
    idle(); step();

    // Write beats increment; reset beats write
    drive(1'b1, 12'hB00, WR, 32'd100); step();
    drive(1'b1, 12'hB00, RD, 32'h0); chk32("mcycle_wr_100", rdata, 32'd100);
    idle(); step();
    drive(1'b1, 12'hB00, RD, 32'h0); chk32("mcycle_101", rdata, 32'd101);
    reset = 1'b1;
    drive(1'b1, 12'hB00, WR, 32'd55); step();
    drive(1'b1, 12'hB00, RD, 32'h0); chk32("rstwr_mcycle", rdata, 32'd0);
    drive(1'b1, 12'hB02, RD, 32'h0); chk32("rstwr_minstret", rdata, 32'd0);
    drive(1'b1, 12'hB03, RD, 32'h0); chk32("rstwr_hpm0", rdata, 32'd0);
    reset = 1'b0; retire = 1'b0; events = 8'h00;
    drive(1'b1, 12'h320, WR, 32'hFFFF_FFFF); step();

    // Read/decode table with all counters frozen
    for (int t = 0; t < 22; t++) begin
      prv = tbl[t].p;
      drive(tbl[t].r, tbl[t].a, tbl[t].c, 32'h0);
      chk32($sformatf("tbl%0d_rdata", t), rdata, tbl[t].exp_rd);
      chk1($sformatf("tbl%0d_illegal", t), illegal_access, tbl[t].exp_ill);
      prv = 2'd3;
      idle(); step();
    end

    // Randomized traffic against the model
    drive(1'b1, 12'h320, WR, 32'h0); step();
    for (int n = 0; n < 3000; n++) begin
      logic [11:0] a;
      logic [2:0]  c;
      logic [31:0] w;
      reset  = ($urandom_range(0, 299) == 0);
      prv    = ($urandom_range(0, 3) != 0) ? 2'd3 : 2'd0;
      retire = 1'($urandom);
      events = 8'($urandom);
      a = ($urandom_range(0, 9) == 0) ? 12'($urandom) : pool[$urandom_range(0, 15)];
      case ($urandom_range(0, 4))
        0: c = NOP; 1: c = RD; 2: c = WR; 3: c = ST; default: c = CL;
      endcase
      case ($urandom_range(0, 3))
        0: w = $urandom;
        1: w = 32'hFFFF_FFFF;
        2: w = 32'hFFFF_FFFF - 32'($urandom_range(0, 6));
        default: w = 32'($urandom_range(0, 10));
      endcase
      drive(1'($urandom_range(0, 3) != 0), a, c, w);
      step();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
